lock_seq_ctrl: RTL

//  Clocked controller for the 5-symbol code lock. Collects key strobes into an

---
 rtl/lock_seq_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/lock_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lock_seq_ctrl
// Brief    : Code-lock controller: key entry, pattern check, fail lockout,
//            reprogramming. Optional AUTO_RELOCK_EN adds an OPEN timeout.
// Revision : 1.0 - initial release
// ============================================================================
module lock_seq_ctrl #(
    parameter int SYM_W       = 3,
    parameter int PAT_LEN     = 5,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 1000,
    parameter int OPEN_CYCLES = 500
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            key_vld_i,
    input  logic [SYM_W-1:0]                key_i,
    input  logic                            clr_i,
    input  logic                            lock_i,
    input  logic                            prog_i,
    output logic                            open_o,
    output logic                            alarm_o,
    output logic                            prog_o,
    output logic [$clog2(PAT_LEN+1)-1:0]    entered_o,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_o
);

    localparam int EW  = $clog2(PAT_LEN + 1);
    localparam int FW  = $clog2(MAX_FAIL + 1);
    localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    // Elaboration-time range checks on the configuration.
    if (MAX_FAIL < 1) begin : g_bad_max_fail
        $error("lock_seq_ctrl: MAX_FAIL must be >= 1");
    end
    if (LOCK_CYCLES < 1) begin : g_bad_lock_cycles
        $error("lock_seq_ctrl: LOCK_CYCLES must be >= 1");
    end
    if (OPEN_CYCLES < 1) begin : g_bad_open_cycles
        $error("lock_seq_ctrl: OPEN_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        ST_LOCKED  = 3'd0,
        ST_CHECK   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_PROGRAM = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [SYM_W-1:0] entry     [PAT_LEN];
    logic [SYM_W-1:0] entry_nxt [PAT_LEN];
    logic [SYM_W-1:0] entry_wr  [PAT_LEN];
    logic [SYM_W-1:0] pattern     [PAT_LEN];
    logic [SYM_W-1:0] pattern_nxt [PAT_LEN];
    logic [EW-1:0]    entered, entered_nxt, entered_inc;
    logic [FW-1:0]    fail_cnt, fail_nxt, fail_inc;
    logic [LCW-1:0]   lock_cnt, lock_cnt_nxt;
    logic             entry_full;
    logic             pattern_match;

`ifdef AUTO_RELOCK_EN
    localparam int OCW = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
    logic [OCW-1:0]   open_cnt, open_cnt_nxt;
`endif

    assign entered_inc = entered + EW'(1);
    assign entry_full  = (entered_inc == EW'(PAT_LEN));
    assign fail_inc    = (fail_cnt == FW'(MAX_FAIL)) ? fail_cnt : fail_cnt + FW'(1);

    // The entry buffer doubles as the program-mode shadow: LOCKED always
    // rewrites every slot before the next CHECK, so leftovers are harmless.
    always_comb begin
        entry_wr = entry;
        for (int i = 0; i < PAT_LEN; i++) begin
            if (entered == EW'(i)) begin
                entry_wr[i] = key_i;
            end
        end
    end

    always_comb begin
        pattern_match = 1'b1;
        for (int j = 0; j < PAT_LEN; j++) begin
            if (entry[j] != pattern[j]) begin
                pattern_match = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= ST_LOCKED;
            entered  <= '0;
            fail_cnt <= '0;
            lock_cnt <= '0;
            for (int i = 0; i < PAT_LEN; i++) begin
                entry[i]   <= '0;
                pattern[i] <= '0;
            end
`ifdef AUTO_RELOCK_EN
            open_cnt <= '0;
`endif
        end else begin
            state    <= state_nxt;
            entered  <= entered_nxt;
            fail_cnt <= fail_nxt;
            lock_cnt <= lock_cnt_nxt;
            entry    <= entry_nxt;
            pattern  <= pattern_nxt;
`ifdef AUTO_RELOCK_EN
            open_cnt <= open_cnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt    = state;
        entered_nxt  = entered;
        fail_nxt     = fail_cnt;
        lock_cnt_nxt = lock_cnt;
        entry_nxt    = entry;
        pattern_nxt  = pattern;
`ifdef AUTO_RELOCK_EN
        open_cnt_nxt = open_cnt;
`endif
        case (state)
            ST_LOCKED: begin
                if (clr_i) begin
                    entered_nxt = '0;
                end else if (key_vld_i) begin
                    entry_nxt   = entry_wr;
                    entered_nxt = entered_inc;
                    if (entry_full) begin
                        state_nxt = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                entered_nxt = '0;
                if (pattern_match) begin
                    state_nxt = ST_OPEN;
                    fail_nxt  = '0;
`ifdef AUTO_RELOCK_EN
                    open_cnt_nxt = OCW'(OPEN_CYCLES - 1);
`endif
                end else begin
                    fail_nxt = fail_inc;
                    if (fail_inc == FW'(MAX_FAIL)) begin
                        state_nxt    = ST_LOCKOUT;
                        lock_cnt_nxt = LCW'(LOCK_CYCLES - 1);
                    end else begin
                        state_nxt = ST_LOCKED;
                    end
                end
            end
            ST_OPEN: begin
                if (lock_i) begin
                    state_nxt = ST_LOCKED;
                end else if (prog_i) begin
                    state_nxt   = ST_PROGRAM;
                    entered_nxt = '0;
                end
`ifdef AUTO_RELOCK_EN
                else if (key_vld_i) begin
                    open_cnt_nxt = OCW'(OPEN_CYCLES - 1);
                end else if (open_cnt == '0) begin
                    state_nxt = ST_LOCKED;
                end else begin
                    open_cnt_nxt = open_cnt - OCW'(1);
                end
`endif
            end
            ST_PROGRAM: begin
                if (!prog_i) begin
                    state_nxt   = ST_OPEN;
                    entered_nxt = '0;
`ifdef AUTO_RELOCK_EN
                    open_cnt_nxt = OCW'(OPEN_CYCLES - 1);
`endif
                end else if (clr_i) begin
                    entered_nxt = '0;
                end else if (key_vld_i) begin
                    entry_nxt = entry_wr;
                    if (entry_full) begin
                        pattern_nxt = entry_wr;
                        state_nxt   = ST_OPEN;
                        entered_nxt = '0;
`ifdef AUTO_RELOCK_EN
                        open_cnt_nxt = OCW'(OPEN_CYCLES - 1);
`endif
                    end else begin
                        entered_nxt = entered_inc;
                    end
                end
            end
            ST_LOCKOUT: begin
                if (lock_cnt == '0) begin
                    state_nxt = ST_LOCKED;
                    fail_nxt  = '0;
                end else begin
                    lock_cnt_nxt = lock_cnt - LCW'(1);
                end
            end
            default: begin
                state_nxt   = ST_LOCKED;
                entered_nxt = '0;
            end
        endcase
    end

    assign open_o    = (state == ST_OPEN);
    assign alarm_o   = (state == ST_LOCKOUT);
    assign prog_o    = (state == ST_PROGRAM);
    assign entered_o = entered;
    assign fail_o    = fail_cnt;

endmodule
`default_nettype wire
